// File: rtl/axil_ss_bridge.sv
// axil_ss_bridge -- AXI4-Lite slave to simple single-cycle device bus.
//
// AR, AW and W beats are buffered in independent REQ_DEPTH-entry queues. A
// small FSM (IDLE -> ISSUE -> CAPTURE -> WAIT -> RESP) services one access at
// a time. It alternates between reads and writes when both are pending, and it
// holds each R/B response until the master takes it.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   s_ar*/s_r*                        AXI4-Lite read address / read data channels
//   s_aw*/s_w*/s_b*                   AXI4-Lite write address / data / response channels
//   dev_req/dev_we/dev_be/dev_addr/dev_wdata   one-cycle device access
//   dev_rdata                         device read data, sampled the cycle after dev_req
//
// Optional feature: define ADDR_DECODE_ERR_EN to enable address decoding.
// A head address with (addr & MASK) != BASE is then never forwarded to the
// device, and the bridge answers it with SLVERR (reads return zero data).

module axil_ss_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

module axil_ss_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                LATENCY   = 1,
    parameter int                REQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE      = 32'h9a100000,
    parameter logic [ADDR_W-1:0] MASK      = 32'hfffffff0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic                dev_req,
    output logic                dev_we,
    output logic [DATA_W/8-1:0] dev_be,
    output logic [ADDR_W-1:0]   dev_addr,
    output logic [DATA_W-1:0]   dev_wdata,
    input  logic [DATA_W-1:0]   dev_rdata
);
    localparam int SW = DATA_W / 8;
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, CAPTURE = 3'd2, WAIT = 3'd3, RESP = 3'd4;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam int         LAT_I  = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0] LAT_M1 = LAT_I[3:0];

    logic [2:0]        state_q, state_d;
    logic              wr_q, wr_d;            // transaction in service is a write
    logic              last_wr_q, last_wr_d;  // arbiter memory
    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;

    logic              ar_full, ar_empty, aw_full, aw_empty, w_full, w_empty;
    logic [ADDR_W-1:0] ar_head, aw_head;
    logic [DATA_W-1:0] w_head_data;
    logic [SW-1:0]     w_head_strb;
    logic              ar_pop, wr_pop;

    assign ar_pop = (state_q == CAPTURE) && !wr_q;
    assign wr_pop = (state_q == CAPTURE) && wr_q;

    axil_ss_fifo #(.W(ADDR_W), .DEPTH(REQ_DEPTH)) u_ar_q (
        .clk(clk), .resetn(resetn), .push_i(s_arvalid), .pop_i(ar_pop),
        .din_i(s_araddr), .dout_o(ar_head), .full_o(ar_full), .empty_o(ar_empty));
    axil_ss_fifo #(.W(ADDR_W), .DEPTH(REQ_DEPTH)) u_aw_q (
        .clk(clk), .resetn(resetn), .push_i(s_awvalid), .pop_i(wr_pop),
        .din_i(s_awaddr), .dout_o(aw_head), .full_o(aw_full), .empty_o(aw_empty));
    axil_ss_fifo #(.W(DATA_W + SW), .DEPTH(REQ_DEPTH)) u_w_q (
        .clk(clk), .resetn(resetn), .push_i(s_wvalid), .pop_i(wr_pop),
        .din_i({s_wstrb, s_wdata}), .dout_o({w_head_strb, w_head_data}),
        .full_o(w_full), .empty_o(w_empty));

    assign s_arready = !ar_full;
    assign s_awready = !aw_full;
    assign s_wready  = !w_full;

    logic rd_pend, wr_pend, grant_wr;
    assign rd_pend  = !ar_empty;
    assign wr_pend  = !aw_empty && !w_empty;
    // When both kinds are pending, take the opposite of the last grant.
    assign grant_wr = (rd_pend && wr_pend) ? !last_wr_q : wr_pend;

    // The head of the granted queue stays put until the CAPTURE pop.
    logic [ADDR_W-1:0] head_addr;
    logic              dec_hit, dec_err;
    assign head_addr = wr_q ? aw_head : ar_head;
    assign dec_hit   = ((head_addr & MASK) == BASE);
`ifdef ADDR_DECODE_ERR_EN
    assign dec_err = !dec_hit;
`else
    logic unused_dec;
    assign dec_err    = 1'b0;
    assign unused_dec = dec_hit;
`endif

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        last_wr_d = last_wr_q;
        wcnt_d    = wcnt_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (rd_pend || wr_pend) begin
                    state_d   = ISSUE;
                    wr_d      = grant_wr;
                    last_wr_d = grant_wr;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                resp_d = dec_err ? SLVERR : OKAY;
                if (!wr_q) rdata_d = dec_err ? '0 : dev_rdata;
                if (LATENCY == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = LAT_M1;
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) state_d = RESP;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            RESP: begin
                if (wr_q ? s_bready : s_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            last_wr_q <= 1'b1;  // so the first contested grant goes to the read
            wcnt_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            last_wr_q <= last_wr_d;
            wcnt_q    <= wcnt_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    logic in_issue, in_resp;
    assign in_issue  = (state_q == ISSUE);
    assign in_resp   = (state_q == RESP);

    assign dev_req   = in_issue && !dec_err;
    assign dev_we    = in_issue && wr_q;
    assign dev_addr  = in_issue ? head_addr : '0;
    assign dev_be    = !in_issue ? '0 : (wr_q ? w_head_strb : {SW{1'b1}});
    assign dev_wdata = (in_issue && wr_q) ? w_head_data : '0;

    assign s_rvalid  = in_resp && !wr_q;
    assign s_bvalid  = in_resp && wr_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = s_rvalid ? resp_q : OKAY;
    assign s_bresp   = s_bvalid ? resp_q : OKAY;
endmodule

// File: tb/tb_axil_ss_bridge.sv
// Bench for axil_ss_bridge (LATENCY=2, REQ_DEPTH=4). A behavioural model tracks
// accepted AXI requests in queues and a word memory. Every cycle it checks the
// device accesses and the R/B responses against them. Directed sequences pin
// the timing, ordering and literal data values.
module tb_axil_ss_bridge;
    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
    logic        s_arvalid = 1'b0, s_awvalid = 1'b0, s_wvalid = 1'b0;
    logic [3:0]  s_wstrb = '0;
    logic        s_rready = 1'b0, s_bready = 1'b0;
    logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        dev_req, dev_we;
    logic [3:0]  dev_be;
    logic [31:0] dev_addr, dev_wdata;
    logic [31:0] dev_rdata = '0;

    axil_ss_bridge #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .REQ_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .dev_req(dev_req), .dev_we(dev_we), .dev_be(dev_be), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_rdata(dev_rdata));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        ncmp++;
        nerr++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic bit dec_err(input logic [31:0] a);
`ifdef ADDR_DECODE_ERR_EN
        return (a & 32'hfffffff0) != 32'h9a100000;
`else
        return (a === 32'hxxxxxxxx);
`endif
    endfunction

    // Device: 16 words indexed by addr[5:2], read data stays stable until the next read.
    logic [31:0] dmem [16];
    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 32'h40 + 32'(i);
        forever begin
            @(negedge clk);
            if (resetn && dev_req) begin
                if (dev_we) begin
                    for (int b = 0; b < 4; b++)
                        if (dev_be[b]) dmem[dev_addr[5:2]][8*b +: 8] = dev_wdata[8*b +: 8];
                end else begin
                    dev_rdata = dmem[dev_addr[5:2]];
                end
            end
        end
    end

    // Model state and observation log.
    typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;
    logic [31:0] arq[$], awq[$];
    wbeat_t      wq[$];
    logic [31:0] mmem [16];
    logic [31:0] rd_log[$];
    bit          svc_log[$];
    int          devreq_n = 0, devreq_cyc = 0, rv_rise_cyc = 0, rv_rise_n = 0, rh_n = 0, bh_n = 0;
    logic        last_we = 0, rv_prev = 0, bv_prev = 0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wdata = '0, last_rdata = '0;
    logic [1:0]  last_rresp = '0, last_bresp = '0;

    initial begin
        for (int i = 0; i < 16; i++) mmem[i] = 32'h40 + 32'(i);
        forever begin
            @(negedge clk);
            if (!resetn) begin
                arq.delete(); awq.delete(); wq.delete();
                rv_prev = 0; bv_prev = 0;
                chk("rst_rvalid", 32'(s_rvalid), 0);
                chk("rst_bvalid", 32'(s_bvalid), 0);
                chk("rst_devreq", 32'(dev_req), 0);
                chk("rst_ready", 32'({s_arready, s_awready, s_wready}), 32'h7);
            end else begin
                chk("rb_excl", 32'(s_rvalid & s_bvalid), 0);
                if (dev_req) begin
                    devreq_n++; devreq_cyc = cyc;
                    last_we = dev_we; last_be = dev_be; last_wdata = dev_wdata;
                    if (dev_we) begin
                        if (awq.size() == 0 || wq.size() == 0) flag("dev_write_unexpected");
                        else begin
                            chk("dev_waddr", dev_addr, awq[0]);
                            chk("dev_wdata", dev_wdata, wq[0].d);
                            chk("dev_wbe", 32'(dev_be), 32'(wq[0].s));
                            chk("dev_wdecode", 32'(dec_err(awq[0])), 0);
                        end
                    end else begin
                        if (arq.size() == 0) flag("dev_read_unexpected");
                        else begin
                            chk("dev_raddr", dev_addr, arq[0]);
                            chk("dev_rbe", 32'(dev_be), 32'hf);
                            chk("dev_rdecode", 32'(dec_err(arq[0])), 0);
                        end
                    end
                end
                if (s_rvalid) begin
                    if (!rv_prev) begin rv_rise_cyc = cyc; rv_rise_n++; end
                    if (arq.size() == 0) flag("r_unexpected");
                    else begin
                        chk("r_data", s_rdata, dec_err(arq[0]) ? 32'h0 : mmem[arq[0][5:2]]);
                        chk("r_resp", 32'(s_rresp), dec_err(arq[0]) ? 32'h2 : 32'h0);
                        if (s_rready) begin
                            rh_n++; last_rdata = s_rdata; last_rresp = s_rresp;
                            rd_log.push_back(s_rdata); svc_log.push_back(1'b0);
                            void'(arq.pop_front());
                        end
                    end
                end
                if (s_bvalid) begin
                    if (awq.size() == 0 || wq.size() == 0) flag("b_unexpected");
                    else begin
                        chk("b_resp", 32'(s_bresp), dec_err(awq[0]) ? 32'h2 : 32'h0);
                        if (s_bready) begin
                            bh_n++; last_bresp = s_bresp; svc_log.push_back(1'b1);
                            if (!dec_err(awq[0]))
                                for (int b = 0; b < 4; b++)
                                    if (wq[0].s[b]) mmem[awq[0][5:2]][8*b +: 8] = wq[0].d[8*b +: 8];
                            void'(awq.pop_front());
                            void'(wq.pop_front());
                        end
                    end
                end
                rv_prev = s_rvalid; bv_prev = s_bvalid;
                if (s_arvalid && s_arready) arq.push_back(s_araddr);
                if (s_awvalid && s_awready) awq.push_back(s_awaddr);
                if (s_wvalid && s_wready) wq.push_back('{d: s_wdata, s: s_wstrb});
            end
        end
    end

    // One cycle of AXI stimulus; hc returns the cycle stamp of the handshake.
    task automatic drive(input bit arv, input logic [31:0] ara, input bit awv, input logic [31:0] awa,
                         input bit wv, input logic [31:0] wd, input logic [3:0] ws, output int hc);
        s_arvalid = arv; s_araddr = ara;
        s_awvalid = awv; s_awaddr = awa;
        s_wvalid = wv; s_wdata = wd; s_wstrb = ws;
        @(negedge clk);
        hc = cyc;
        if (arv) chk("hs_arready", 32'(s_arready), 1);
        if (awv) chk("hs_awready", 32'(s_awready), 1);
        if (wv)  chk("hs_wready", 32'(s_wready), 1);
        @(posedge clk); #1;
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    endtask

    task automatic wait_quiet(input int n);
        bit done = 0;
        for (int k = 0; k < n && !done; k++) begin
            @(negedge clk);
            if (arq.size() == 0 && awq.size() == 0 && wq.size() == 0 && !s_rvalid && !s_bvalid) done = 1;
        end
        if (!done) flag("timeout_waiting_idle");
        @(posedge clk); #1;
    endtask

    task automatic read_expect(input string nm, input logic [31:0] a, input logic [31:0] exp);
        int hc;
        drive(1, a, 0, 0, 0, 0, 0, hc);
        wait_quiet(60);
        chk(nm, last_rdata, exp);
    endtask

    initial begin
        int hc, hc2, n0, r0, b0;
        logic [5:0] rdy;
        bit got;
        logic [31:0] exp3 [6];
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", s_rdata, 0);
        chk("rst_resp", 32'({s_rresp, s_bresp}), 0);
        chk("rst_dev", 32'({dev_we, dev_be}), 0);
        chk("rst_devaddr", dev_addr, 0);
        chk("rst_devwdata", dev_wdata, 0);
        resetn = 1;
        s_rready = 1; s_bready = 1;
        @(posedge clk); #1;

        // 1: read with LATENCY=2
        n0 = devreq_n;
        drive(1, 32'h9a100004, 0, 0, 0, 0, 0, hc);
        wait_quiet(60);
        chk("t1_devreq_count", 32'(devreq_n - n0), 1);
        chk("t1_issue_cycle", 32'(devreq_cyc - hc), 2);
        chk("t1_we_be", 32'({last_we, last_be}), 32'h0f);
        chk("t1_rvalid_cycle", 32'(rv_rise_cyc - hc), 6);
        chk("t1_rdata", last_rdata, 32'h41);
        chk("t1_rresp", 32'(last_rresp), 0);

        // 2: AW in cycle 0, W in cycle 3
        n0 = devreq_n; b0 = bh_n;
        drive(0, 0, 1, 32'h9a100008, 0, 0, 0, hc);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1, 32'h5a, 4'h1, hc2);
        chk("t2_no_early_req", 32'(devreq_n - n0), 0);
        wait_quiet(60);
        chk("t2_devreq_count", 32'(devreq_n - n0), 1);
        chk("t2_issue_cycle", 32'(devreq_cyc - hc), 5);
        chk("t2_we_be", 32'({last_we, last_be}), 32'h11);
        chk("t2_wdata", last_wdata, 32'h5a);
        chk("t2_b_count", 32'(bh_n - b0), 1);
        chk("t2_bresp", 32'(last_bresp), 0);
        read_expect("t2_readback", 32'h9a100008, 32'h5a);

        // 3: queue fill with R backpressure
        s_rready = 0; rd_log.delete();
        for (int i = 0; i < 6; i++) begin
            s_araddr = 32'h9a100000 + 32'(4 * (i % 4)); s_arvalid = 1;
            @(negedge clk);
            rdy[i] = s_arready;
            @(posedge clk); #1;
        end
        chk("t3_ready_pattern", 32'(rdy), 32'h1f);
        repeat (4) begin
            @(negedge clk);
            chk("t3_full_hold", 32'(s_arready), 0);
        end
        @(posedge clk); #1;
        s_rready = 1;
        @(negedge clk);
        chk("t3_rvalid_held", 32'(s_rvalid), 1);
        @(posedge clk); #1;
        s_rready = 0;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (s_arready) got = 1;
        end
        chk("t3_slot_freed", 32'(got), 1);
        @(posedge clk); #1;
        s_arvalid = 0; s_rready = 1;
        wait_quiet(200);
        exp3 = '{32'h40, 32'h41, 32'h5a, 32'h43, 32'h40, 32'h41};
        chk("t3_resp_count", 32'(rd_log.size()), 6);
        for (int i = 0; i < 6 && i < rd_log.size(); i++) chk("t3_order", rd_log[i], exp3[i]);

        // 4: read and write contending after reset
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        @(posedge clk); #1;
        svc_log.delete();
        drive(1, 32'h9a10000c, 1, 32'h9a100004, 1, 32'h11223344, 4'hf, hc);
        drive(1, 32'h9a100000, 1, 32'h9a10000c, 1, 32'ha5a5a5a5, 4'hc, hc);
        wait_quiet(200);
        chk("t4_svc_count", 32'(svc_log.size()), 4);
        if (svc_log.size() == 4)
            chk("t4_svc_order", 32'({svc_log[0], svc_log[1], svc_log[2], svc_log[3]}), 32'b0101);
        read_expect("t4_readback_c", 32'h9a10000c, 32'ha5a50043);
        read_expect("t4_readback_4", 32'h9a100004, 32'h11223344);

        // 5: reset while waiting for the response
        drive(1, 32'h9a100000, 0, 0, 0, 0, 0, hc);
        drive(1, 32'h9a100004, 0, 0, 0, 0, 0, hc);
        repeat (2) @(posedge clk);
        #3;
        resetn = 0;
        #1;
        chk("t5_rvalid_low", 32'(s_rvalid), 0);
        chk("t5_readys", 32'({s_arready, s_awready, s_wready}), 32'h7);
        n0 = devreq_n; r0 = rv_rise_n;
        @(posedge clk); #1;
        resetn = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_devreq", 32'(devreq_n - n0), 0);
        chk("t5_no_response", 32'(rv_rise_n - r0), 0);

        // 6: out-of-range address, then an in-range one
        n0 = devreq_n;
        drive(1, 32'h80001000, 0, 0, 0, 0, 0, hc);
        wait_quiet(60);
`ifdef ADDR_DECODE_ERR_EN
        chk("t6_bad_devreq", 32'(devreq_n - n0), 0);
        chk("t6_bad_rresp", 32'(last_rresp), 2);
        chk("t6_bad_rdata", last_rdata, 0);
`else
        chk("t6_any_devreq", 32'(devreq_n - n0), 1);
        chk("t6_any_rresp", 32'(last_rresp), 0);
        chk("t6_any_rdata", last_rdata, 32'h40);
`endif
        n0 = devreq_n;
        read_expect("t6_good_rdata", 32'h9a100000, 32'h40);
        chk("t6_good_rresp", 32'(last_rresp), 0);
        chk("t6_good_devreq", 32'(devreq_n - n0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
